// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding, FSM states, op decode helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package muldiv_pkg;

    // mul_para encoding (RV M-extension funct3 order)
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_e;

    function automatic logic md_is_div(input logic [2:0] para);
        return para[2];
    endfunction

    function automatic logic md_is_signed_rs0(input logic [2:0] para);
        return (para == MD_MULH) || (para == MD_MULHSU) ||
               (para == MD_DIV)  || (para == MD_REM);
    endfunction

    function automatic logic md_is_signed_rs1(input logic [2:0] para);
        return (para == MD_MULH) || (para == MD_DIV) || (para == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring radix-2 divide iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs.
// Ports: rem_i/quo_i partial remainder and dividend-shifting quotient in,
//        dvs_i divisor, rem_o/quo_o updated remainder and quotient.
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // The dividend bits are shifted out of the top of quo_i while quotient
    // bits are shifted in at the bottom, so one register serves both.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_i};

    // diff[XLEN] is the borrow: set means the divisor did not fit, so restore.
    assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
    assign rem_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV M-extension multiply/divide with an issue tag carried to the result.
// Latency: mul XLEN/MUL_BITS+1 edges, div XLEN+1 edges (1 edge for trivial cases with MULDIV_EARLY_OUT_EN).
// Backpressure: one op in flight; mul_ready only in IDLE, result held in DONE until mul_ack.
// Ports: clk/rst (async, active-high), clear_pipeline flush, mul_initial/mul_para/mul_rs0/
//        mul_rs1/mul_tag issue, mul_ready, mul_finished/mul_data/mul_tag_out result, mul_ack.
// Optional macro MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero /
// signed-overflow divides skip CALC; results are unchanged.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_pipeline,
    input  logic             mul_initial,
    input  logic [2:0]       mul_para,
    input  logic [XLEN-1:0]  mul_rs0,
    input  logic [XLEN-1:0]  mul_rs1,
    input  logic [TAG_W-1:0] mul_tag,
    output logic             mul_ready,
    output logic             mul_finished,
    output logic [XLEN-1:0]  mul_data,
    output logic [TAG_W-1:0] mul_tag_out,
    input  logic             mul_ack
);

    localparam int W2 = 2 * XLEN;
    localparam int CW = $clog2(XLEN) + 1;

    md_state_e        state_q, state_d;
    logic [2:0]       para_q, para_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [W2-1:0]    acc_q, acc_d;      // mul: product; div: {remainder, quotient}
    logic [W2-1:0]    mcand_q, mcand_d;  // mul: multiplicand, shifted left per step
    logic [XLEN-1:0]  opb_q, opb_d;      // mul: multiplier (shifted right); div: divisor
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;      // product / quotient must be negated
    logic             rneg_q, rneg_d;    // remainder must be negated (dividend sign)
    logic             div0_q, div0_d;    // signed quotient of x/0 is all ones, not -(all ones)

    logic             accept;
    logic             sa, sb;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic [W2-1:0]    pp;
    logic [W2-1:0]    prod;
    logic [XLEN-1:0]  quo, rem;
    logic [XLEN-1:0]  step_rem, step_quo;

`ifdef MULDIV_EARLY_OUT_EN
    logic             div_ovf;
    logic             mul_zero;
`endif

    assign mul_ready    = (state_q == ST_IDLE);
    assign mul_finished = (state_q == ST_DONE);
    assign mul_data     = data_q;
    assign mul_tag_out  = tag_out_q;

    assign accept = (state_q == ST_IDLE) && mul_initial && !clear_pipeline;

    // Signed operands become magnitudes; the core only ever sees unsigned values.
    assign sa    = md_is_signed_rs0(mul_para) && mul_rs0[XLEN-1];
    assign sb    = md_is_signed_rs1(mul_para) && mul_rs1[XLEN-1];
    assign mag_a = sa ? -mul_rs0 : mul_rs0;
    assign mag_b = sb ? -mul_rs1 : mul_rs1;

`ifdef MULDIV_EARLY_OUT_EN
    assign div_ovf  = sa && sb && (mul_rs0 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (mul_rs1 == {XLEN{1'b1}});
    assign mul_zero = (mul_rs0 == '0) || (mul_rs1 == '0);
`endif

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (acc_q[W2-1:XLEN]),
        .quo_i (acc_q[XLEN-1:0]),
        .dvs_i (opb_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            para_q    <= '0;
            tag_q     <= '0;
            tag_out_q <= '0;
            data_q    <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            para_q    <= para_d;
            tag_q     <= tag_d;
            tag_out_q <= tag_out_d;
            data_q    <= data_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            div0_q    <= div0_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        para_d    = para_q;
        tag_d     = tag_q;
        tag_out_d = tag_out_q;
        data_d    = data_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        div0_d    = div0_q;
        pp        = '0;
        prod      = '0;
        quo       = '0;
        rem       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    para_d  = mul_para;
                    tag_d   = mul_tag;
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    div0_d  = md_is_div(mul_para) && (mul_rs1 == '0);
                    opb_d   = mag_b;
                    state_d = ST_CALC;
                    if (md_is_div(mul_para)) begin
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        mcand_d = '0;
                        cnt_d   = CW'(XLEN);
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{XLEN{1'b0}}, mag_a};
                        cnt_d   = CW'(XLEN / MUL_BITS);
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    // Preload the magnitudes CALC would have produced, then let FIX
                    // apply the same sign handling as the long path.
                    if (md_is_div(mul_para) && (mul_rs1 == '0)) begin
                        acc_d   = {mag_a, {XLEN{1'b1}}};
                        state_d = ST_FIX;
                    end else if (md_is_div(mul_para) && div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        state_d = ST_FIX;
                    end else if (!md_is_div(mul_para) && mul_zero) begin
                        acc_d   = '0;
                        state_d = ST_FIX;
                    end
`endif
                end
            end

            ST_CALC: begin
                if (md_is_div(para_q)) begin
                    acc_d = {step_rem, step_quo};
                end else begin
                    for (int j = 0; j < MUL_BITS; j++) begin
                        if (opb_q[j]) pp = pp + (mcand_q << j);
                    end
                    acc_d   = acc_q + pp;
                    mcand_d = mcand_q << MUL_BITS;
                    opb_d   = opb_q >> MUL_BITS;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_FIX;
            end

            ST_FIX: begin
                prod = neg_q ? -acc_q : acc_q;
                quo  = div0_q ? {XLEN{1'b1}}
                              : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
                rem  = rneg_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
                unique case (para_q)
                    MD_MUL:                       data_d = prod[XLEN-1:0];
                    MD_MULH, MD_MULHSU, MD_MULHU: data_d = prod[W2-1:XLEN];
                    MD_DIV, MD_DIVU:              data_d = quo;
                    MD_REM, MD_REMU:              data_d = rem;
                    default:                      data_d = '0;
                endcase
                tag_out_d = tag_q;
                state_d   = ST_DONE;
            end

            ST_DONE: begin
                if (mul_ack) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // Flush overrides every transition, including a same-cycle issue.
        if (clear_pipeline) state_d = ST_IDLE;
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench: 32-bit/radix-4 instance for directed latency and value
// vectors, 64-bit/radix-16 instance for randomised ops against a behavioural model.
// Ends with one TB_RESULT summary line.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_pipeline = 1'b0;

    logic        mul_initial = 1'b0;
    logic [2:0]  mul_para = '0;
    logic [31:0] mul_rs0 = '0;
    logic [31:0] mul_rs1 = '0;
    logic [3:0]  mul_tag = '0;
    logic        mul_ready;
    logic        mul_finished;
    logic [31:0] mul_data;
    logic [3:0]  mul_tag_out;
    logic        mul_ack = 1'b0;

    logic        w_init = 1'b0;
    logic [2:0]  w_para = '0;
    logic [63:0] w_a = '0;
    logic [63:0] w_b = '0;
    logic [3:0]  w_tag = '0;
    logic        w_ready;
    logic        w_fin;
    logic [63:0] w_data;
    logic [3:0]  w_tagout;
    logic        w_ack = 1'b0;

    int checks   = 0;
    int failures = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 33;
`endif
`ifdef MULDIV_EARLY_OUT_EN
    localparam int MUL0_LAT = 1;
`else
    localparam int MUL0_LAT = 17;
`endif

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(32), .MUL_BITS(2), .TAG_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .clear_pipeline (clear_pipeline),
        .mul_initial    (mul_initial),
        .mul_para       (mul_para),
        .mul_rs0        (mul_rs0),
        .mul_rs1        (mul_rs1),
        .mul_tag        (mul_tag),
        .mul_ready      (mul_ready),
        .mul_finished   (mul_finished),
        .mul_data       (mul_data),
        .mul_tag_out    (mul_tag_out),
        .mul_ack        (mul_ack)
    );

    muldiv_iter #(.XLEN(64), .MUL_BITS(4), .TAG_W(4)) dut64 (
        .clk            (clk),
        .rst            (rst),
        .clear_pipeline (clear_pipeline),
        .mul_initial    (w_init),
        .mul_para       (w_para),
        .mul_rs0        (w_a),
        .mul_rs1        (w_b),
        .mul_tag        (w_tag),
        .mul_ready      (w_ready),
        .mul_finished   (w_fin),
        .mul_data       (w_data),
        .mul_tag_out    (w_tagout),
        .mul_ack        (w_ack)
    );

    // Behavioural RV64 M-extension reference using native wide arithmetic.
    function automatic logic [63:0] ref64(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [127:0] xs, ys, xu, yu, p;
        logic signed [63:0]  as_, bs_;
        logic                ovf;
        xs  = {{64{a[63]}}, a};
        ys  = {{64{b[63]}}, b};
        xu  = {64'd0, a};
        yu  = {64'd0, b};
        as_ = a;
        bs_ = b;
        ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        case (op)
            3'd0: begin p = xu * yu; return p[63:0];   end
            3'd1: begin p = xs * ys; return p[127:64]; end
            3'd2: begin p = xs * yu; return p[127:64]; end
            3'd3: begin p = xu * yu; return p[127:64]; end
            3'd4: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? a : 64'(as_ / bs_));
            3'd5: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 64'd0 : 64'(as_ % bs_));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one op on the 32-bit unit, measure edges after accept, then ack.
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, output int lat, output logic [31:0] res,
                         output logic [3:0] rtag);
        mul_para = op; mul_rs0 = a; mul_rs1 = b; mul_tag = tag; mul_initial = 1'b1;
        @(posedge clk); #1;
        mul_initial = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!mul_finished && lat < 100);
        res  = mul_data;
        rtag = mul_tag_out;
        checks++;
        if (!mul_finished) begin
            failures++;
            $display("FAIL run32_timeout op=%0d got no finish, required finish within 100", op);
        end
        mul_ack = 1'b1;
        @(posedge clk); #1;
        mul_ack = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({mul_ready, mul_finished, mul_data, mul_tag_out} !== {1'b1, 1'b0, 32'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b fin=%b data=%h tag=%h required 1 0 0 0",
                     mul_ready, mul_finished, mul_data, mul_tag_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk32(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] exp, input int exp_lat);
        int          lat;
        logic [31:0] res;
        logic [3:0]  rtag;
        run32(op, a, b, tag, lat, res, rtag);
        checks++;
        if (res !== exp || rtag !== tag) begin
            failures++;
            $display("FAIL %s got data=%h tag=%h required data=%h tag=%h", name, res, rtag, exp, tag);
        end
        if (exp_lat > 0) begin
            checks++;
            if (lat != exp_lat) begin
                failures++;
                $display("FAIL %s_latency got %0d required %0d", name, lat, exp_lat);
            end
        end
    endtask

    task automatic test_basic();
        chk32("mul_basic", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 4'h3, 32'hFFFF_FFEB, 17);
        chk32("div_basic", 3'd4, 32'h8000_0000, 32'h0000_0003, 4'hA, 32'hD555_5556, 33);
        chk32("rem_basic", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 4'h6, 32'hFFFF_FFFF, 33);
        chk32("divu_basic", 3'd5, 32'd100, 32'd7, 4'h1, 32'd14, 33);
    endtask

    task automatic test_high_mul();
        chk32("mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h1, 32'h0000_0000, 17);
        chk32("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 4'h2, 32'h8000_0000, 17);
        chk32("mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'h4, 32'h7FFF_FFFF, 17);
    endtask

    task automatic test_special_div();
        chk32("divu_by0", 3'd5, 32'h1234_5678, 32'd0, 4'h5, 32'hFFFF_FFFF, FAST_LAT);
        chk32("remu_by0", 3'd7, 32'h1234_5678, 32'd0, 4'h6, 32'h1234_5678, FAST_LAT);
        chk32("div_neg_by0", 3'd4, 32'hFFFF_FFF0, 32'd0, 4'h7, 32'hFFFF_FFFF, FAST_LAT);
        chk32("rem_neg_by0", 3'd6, 32'hFFFF_FFF0, 32'd0, 4'h8, 32'hFFFF_FFF0, FAST_LAT);
        chk32("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'h9, 32'h8000_0000, FAST_LAT);
        chk32("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'hB, 32'h0000_0000, FAST_LAT);
        chk32("mul_zero", 3'd0, 32'd0, 32'h1234_5678, 4'hC, 32'd0, MUL0_LAT);
    endtask

    task automatic test_flush();
        int seen;
        // Flush during CALC with a competing issue on the same edge.
        mul_para = 3'd4; mul_rs0 = 32'd1000; mul_rs1 = 32'd3; mul_tag = 4'hD; mul_initial = 1'b1;
        @(posedge clk); #1;
        mul_initial = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        clear_pipeline = 1'b1;
        mul_initial = 1'b1; mul_para = 3'd0;
        @(posedge clk); #1;
        clear_pipeline = 1'b0;
        mul_initial = 1'b0;
        checks++;
        if (mul_ready !== 1'b1 || mul_finished !== 1'b0) begin
            failures++;
            $display("FAIL flush_calc got rdy=%b fin=%b required rdy=1 fin=0", mul_ready, mul_finished);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (mul_finished || !mul_ready) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_no_result got %0d busy/finished cycles required 0", seen);
        end
        // Flush while a result waits in DONE.
        mul_para = 3'd0; mul_rs0 = 32'd6; mul_rs1 = 32'd7; mul_tag = 4'h2; mul_initial = 1'b1;
        @(posedge clk); #1;
        mul_initial = 1'b0;
        repeat (17) begin @(posedge clk); #1; end
        checks++;
        if (mul_finished !== 1'b1 || mul_data !== 32'd42) begin
            failures++;
            $display("FAIL flush_pre_done got fin=%b data=%h required fin=1 data=0000002a",
                     mul_finished, mul_data);
        end
        clear_pipeline = 1'b1;
        @(posedge clk); #1;
        clear_pipeline = 1'b0;
        checks++;
        if (mul_ready !== 1'b1 || mul_finished !== 1'b0) begin
            failures++;
            $display("FAIL flush_done got rdy=%b fin=%b required rdy=1 fin=0", mul_ready, mul_finished);
        end
        chk32("after_flush", 3'd5, 32'd91, 32'd10, 4'hE, 32'd9, 33);
    endtask

    task automatic test_back_to_back();
        int lat;
        // Ack held high throughout: ignored outside DONE, gives a one-cycle DONE.
        mul_ack = 1'b1;
        mul_para = 3'd0; mul_rs0 = 32'd9; mul_rs1 = 32'd11; mul_tag = 4'h7; mul_initial = 1'b1;
        @(posedge clk); #1;
        mul_initial = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!mul_finished && lat < 100);
        checks++;
        if (lat != 17 || mul_data !== 32'd99 || mul_tag_out !== 4'h7) begin
            failures++;
            $display("FAIL b2b_first got lat=%0d data=%h tag=%h required 17 00000063 7",
                     lat, mul_data, mul_tag_out);
        end
        mul_para = 3'd5; mul_rs0 = 32'd50; mul_rs1 = 32'd5; mul_tag = 4'h8; mul_initial = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mul_finished !== 1'b0 || mul_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ack got fin=%b rdy=%b required fin=0 rdy=1", mul_finished, mul_ready);
        end
        @(posedge clk); #1;
        mul_initial = 1'b0;
        checks++;
        if (mul_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept got rdy=%b required 0", mul_ready);
        end
        lat = 1;
        do begin @(posedge clk); #1; lat++; end while (!mul_finished && lat < 100);
        checks++;
        if (mul_data !== 32'd10 || mul_tag_out !== 4'h8) begin
            failures++;
            $display("FAIL b2b_second got data=%h tag=%h required 0000000a 8", mul_data, mul_tag_out);
        end
        @(posedge clk); #1;
        mul_ack = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        int seen;
        mul_para = 3'd4; mul_rs0 = 32'h8000_0000; mul_rs1 = 32'd3; mul_tag = 4'h5; mul_initial = 1'b1;
        @(posedge clk); #1;
        mul_initial = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if ({mul_ready, mul_finished, mul_data, mul_tag_out} !== {1'b1, 1'b0, 32'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset_mid_div got rdy=%b fin=%b data=%h tag=%h required 1 0 0 0",
                     mul_ready, mul_finished, mul_data, mul_tag_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (mul_finished) seen++; end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_no_result got %0d finished cycles required 0", seen);
        end
        chk32("after_reset", 3'd4, 32'h8000_0000, 32'd3, 4'h5, 32'hD555_5556, 33);
    endtask

    task automatic test_random64();
        logic [63:0] exp, held;
        logic [2:0]  op;
        int          cnt, dly;
        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            w_para = op; w_a = pick64(); w_b = pick64(); w_tag = 4'($urandom);
            exp = ref64(op, w_a, w_b);
            w_init = 1'b1;
            @(posedge clk); #1;
            w_init = 1'b0;
            cnt = 0;
            do begin @(posedge clk); #1; cnt++; end while (!w_fin && cnt < 200);
            checks++;
            if (!w_fin) begin
                failures++;
                $display("FAIL rand_timeout op=%0d no finish required finish within 200", op);
                continue;
            end
            checks++;
            if (w_data !== exp || w_tagout !== w_tag) begin
                failures++;
                $display("FAIL rand_result op=%0d a=%h b=%h got data=%h tag=%h required data=%h tag=%h",
                         op, w_a, w_b, w_data, w_tagout, exp, w_tag);
            end
            held = w_data;
            dly  = $urandom_range(0, 15);
            repeat (dly) begin
                @(posedge clk); #1;
                checks++;
                if (w_data !== held || w_fin !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_hold got data=%h fin=%b required data=%h fin=1",
                             w_data, w_fin, held);
                end
            end
            w_ack = 1'b1;
            @(posedge clk); #1;
            w_ack = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_high_mul();
        test_special_div();
        test_flush();
        test_back_to_back();
        test_reset_mid_div();
        test_random64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
